// File: rtl/wb_arb_pkg.sv
// Shared state codes and sizing helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    // Index width never drops below one bit so a single-master build still has a legal port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int t);
        return (t > 1) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr wins, wrapping to the lowest index.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[k] && (IDX_W'(k) >= ptr)) begin
                valid = 1'b1;
                idx   = IDX_W'(k);
            end
        end
        // Nothing at or above the pointer: the lowest requester is next in rotation.
        for (int k = 0; k < N; k++) begin
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int k = 0; k < N; k++) begin
            gnt[k] = valid && (idx == IDX_W'(k));
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: N masters share one slave, grant held for a whole cyc,
// with a watchdog that aborts stalled strobes and records the offending master.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255,
    localparam int SW       = DW / 8,
    localparam int IDX_W    = idx_width(N_MASTERS)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic [N_MASTERS-1:0]    m_cyc_i,
    input  logic [N_MASTERS-1:0]    m_stb_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [N_MASTERS*SW-1:0] m_sel_i,
    input  logic [N_MASTERS*AW-1:0] m_adr_i,
    input  logic [N_MASTERS*DW-1:0] m_dat_i,
    output logic [N_MASTERS-1:0]    m_ack_o,
    output logic [N_MASTERS-1:0]    m_err_o,
    output logic [DW-1:0]           m_dat_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [SW-1:0]           s_sel_o,
    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic [DW-1:0]           s_dat_i,
    output logic [N_MASTERS-1:0]    grant_o,
    output logic                    timeout_o,
    output logic [IDX_W-1:0]        timeout_idx_o,
    input  logic                    clr_timeout_i
);

    localparam int                CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_MASTERS - 1);

    logic [1:0]           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 abort_err_q, abort_err_d;
    logic                 timeout_q, timeout_d;
    logic [IDX_W-1:0]     tidx_q, tidx_d;

    logic [N_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    logic                 g_cyc, g_stb, g_we;
    logic [SW-1:0]        g_sel;
    logic [AW-1:0]        g_adr;
    logic [DW-1:0]        g_dat;
    logic                 resp_ack, resp_err;

    rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (m_cyc_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        g_cyc = m_cyc_i[gidx_q];
        g_stb = m_stb_i[gidx_q];
        g_we  = m_we_i[gidx_q];
        g_sel = m_sel_i[gidx_q*SW +: SW];
        g_adr = m_adr_i[gidx_q*AW +: AW];
        g_dat = m_dat_i[gidx_q*DW +: DW];
    end

    // Slave side is driven only while BUSY; IDLE and ABORT keep the bus quiet.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m_dat_o  = '0;
        resp_ack = 1'b0;
        resp_err = 1'b0;
        case (state_q)
            ST_BUSY: begin
                s_cyc_o  = g_cyc;
                s_stb_o  = g_cyc & g_stb;
                s_we_o   = g_we;
                s_sel_o  = g_sel;
                s_adr_o  = g_adr;
                s_dat_o  = g_dat;
                m_dat_o  = s_dat_i;
                resp_ack = g_cyc & s_ack_i & ~s_err_i;
                resp_err = g_cyc & s_err_i;
            end
            ST_ABORT: resp_err = abort_err_q;
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_resp
        assign m_ack_o[gi] = resp_ack & (gidx_q == IDX_W'(gi));
        assign m_err_o[gi] = resp_err & (gidx_q == IDX_W'(gi));
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        abort_err_d = 1'b0;
        timeout_d   = timeout_q;
        tidx_d      = tidx_q;
        if (clr_timeout_i) begin
            timeout_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    ptr_d   = (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (s_ack_i || s_err_i) begin
                    cnt_d = '0;
                end else if (s_stb_o && (TIMEOUT != 0)) begin
                    // A new timeout in the same cycle as a clear still sets the flag.
                    if (cnt_q == CNT_LAST) begin
                        state_d     = ST_ABORT;
                        abort_err_d = 1'b1;
                        timeout_d   = 1'b1;
                        tidx_d      = gidx_q;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ABORT: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            abort_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            tidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            abort_err_q <= abort_err_d;
            timeout_q   <= timeout_d;
            tidx_q      <= tidx_d;
        end
    end

    assign grant_o       = grant_q;
    assign timeout_o     = timeout_q;
    assign timeout_idx_o = tidx_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with two masters and an 8-cycle watchdog.
module tb_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*SW-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0]   s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic            s_ack_i, s_err_i;
    logic [DW-1:0]   s_dat_i;
    logic            timeout_o;
    logic [0:0]      timeout_idx_o;
    logic            clr_timeout;
    logic            ack_en, err_en, force_ack;

    always #5 clk = ~clk;

    // Slave model: zero-wait response, read data derived from the address.
    assign s_ack_i = (s_stb_o & ack_en) | force_ack;
    assign s_err_i = s_stb_o & err_en;
    assign s_dat_i = s_adr_o ^ 32'h5A5A_5A5A;

    wb_rr_arbiter #(
        .N_MASTERS (N),
        .AW        (AW),
        .DW        (DW),
        .TIMEOUT   (TO)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .m_cyc_i       (m_cyc),
        .m_stb_i       (m_stb),
        .m_we_i        (m_we),
        .m_sel_i       (m_sel),
        .m_adr_i       (m_adr),
        .m_dat_i       (m_dat),
        .m_ack_o       (m_ack_o),
        .m_err_o       (m_err_o),
        .m_dat_o       (m_dat_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_we_o        (s_we_o),
        .s_sel_o       (s_sel_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_ack_i       (s_ack_i),
        .s_err_i       (s_err_i),
        .s_dat_i       (s_dat_i),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o),
        .timeout_idx_o (timeout_idx_o),
        .clr_timeout_i (clr_timeout)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        $display("check %0d %s observed=0x%0h expected=0x%0h", checks, tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=0x%0h expected=queued_entry", obs);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic wait_stb(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_stb_o) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL %s_wait observed=no_stb expected=stb_within_20", tag);
        end
    endtask

    task automatic clear_masters();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        m_sel = '0;
        m_adr = '0;
        m_dat = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_masters();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] t2_adr(input int k, input int n);
        return 32'h1000_0000 + 32'(k << 8) + 32'(n);
    endfunction

    initial begin
        int          done[N];
        int          total;
        int          stb_cnt;
        logic [N-1:0] prev;
        logic [N-1:0] dropped;

        rst_n       = 1'b0;
        clear_masters();
        clr_timeout = 1'b0;
        ack_en      = 1'b1;
        err_en      = 1'b0;
        force_ack   = 1'b0;

        // 1: requests held during reset must not produce a grant.
        m_cyc = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
        chk("rst_s_stb", 64'(s_stb_o), 64'h0);
        chk("rst_timeout", 64'(timeout_o), 64'h0);
        chk("rst_tidx", 64'(timeout_idx_o), 64'h0);
        chk("rst_m_ack", 64'(m_ack_o), 64'h0);
        chk("rst_m_err", 64'(m_err_o), 64'h0);
        chk("rst_m_dat", 64'(m_dat_o), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_grant", 64'(grant_o), 64'h1);
        chk("t1_s_cyc", 64'(s_cyc_o), 64'h1);
        m_cyc = 2'b00;
        @(negedge clk);

        // 2: both masters request continuously; grants alternate with an idle cycle between.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            push("t2_grant", 64'(1 << (t % 2)));
            push("t2_ack", 64'(1 << (t % 2)));
            push("t2_rdat", 64'(t2_adr(t % 2, t / 2) ^ 32'h5A5A_5A5A));
        end
        done[0] = 0;
        done[1] = 0;
        total   = 0;
        prev    = '0;
        m_cyc   = 2'b11;
        m_stb   = 2'b11;
        m_adr   = {t2_adr(1, 0), t2_adr(0, 0)};
        for (int cy = 0; cy < 100 && total < 8; cy++) begin
            @(negedge clk);
            dropped = '0;
            if (grant_o != '0 && prev == '0) begin
                pop_chk(64'(grant_o));
            end
            if (grant_o != '0 && prev != '0) begin
                chk("t2_hold", 64'(grant_o), 64'(prev));
            end
            if (m_ack_o != '0) begin
                pop_chk(64'(m_ack_o));
                pop_chk(64'(m_dat_o));
                for (int k = 0; k < N; k++) begin
                    if (m_ack_o[k]) begin
                        done[k]++;
                        total++;
                        m_cyc[k]   = 1'b0;
                        m_stb[k]   = 1'b0;
                        dropped[k] = 1'b1;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!m_cyc[k] && !dropped[k] && done[k] < 4) begin
                    m_cyc[k]          = 1'b1;
                    m_stb[k]          = 1'b1;
                    m_adr[k*AW +: AW] = t2_adr(k, done[k]);
                end
            end
            prev = grant_o;
        end
        chk("t2_total", 64'(total), 64'd8);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        clear_masters();
        @(negedge clk);

        // 3: lone write from master 1 reaches the slave untouched.
        push("t3_s_adr", 64'h3000_0004);
        push("t3_s_dat", 64'hDEAD_BEEF);
        push("t3_s_sel", 64'hF);
        push("t3_s_we", 64'h1);
        push("t3_m_ack", 64'h2);
        push("t3_m_dat", 64'(32'h3000_0004 ^ 32'h5A5A_5A5A));
        m_cyc           = 2'b10;
        m_stb           = 2'b10;
        m_we            = 2'b10;
        m_sel[7:4]      = 4'hF;
        m_adr[63:32]    = 32'h3000_0004;
        m_dat[63:32]    = 32'hDEAD_BEEF;
        wait_stb("t3");
        pop_chk(64'(s_adr_o));
        pop_chk(64'(s_dat_o));
        pop_chk(64'(s_sel_o));
        pop_chk(64'(s_we_o));
        pop_chk(64'(m_ack_o));
        pop_chk(64'(m_dat_o));
        clear_masters();
        @(negedge clk);

        // 4: silent slave; watchdog aborts master 1 after TO strobe cycles.
        ack_en = 1'b0;
        m_cyc  = 2'b10;
        m_stb  = 2'b10;
        wait_stb("t4");
        stb_cnt = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!s_stb_o) break;
            stb_cnt++;
        end
        chk("t4_stb_cycles", 64'(stb_cnt), 64'(TO));
        chk("t4_s_cyc", 64'(s_cyc_o), 64'h0);
        chk("t4_m_err", 64'(m_err_o), 64'h2);
        chk("t4_timeout", 64'(timeout_o), 64'h1);
        chk("t4_tidx", 64'(timeout_idx_o), 64'h1);
        chk("t4_grant_held", 64'(grant_o), 64'h2);
        @(negedge clk);
        chk("t4_err_one_cycle", 64'(m_err_o), 64'h0);
        chk("t4_slave_quiet", 64'(s_cyc_o), 64'h0);
        clr_timeout = 1'b1;
        @(negedge clk);
        clr_timeout = 1'b0;
        chk("t4_clr", 64'(timeout_o), 64'h0);
        clear_masters();
        @(negedge clk);
        chk("t4_release", 64'(grant_o), 64'h0);

        // 5a: ack and err together -> err only.
        ack_en = 1'b1;
        err_en = 1'b1;
        m_cyc  = 2'b01;
        m_stb  = 2'b01;
        wait_stb("t5a");
        chk("t5a_m_err", 64'(m_err_o), 64'h1);
        chk("t5a_m_ack", 64'(m_ack_o), 64'h0);
        clear_masters();
        @(negedge clk);

        // 5b: clear coinciding with a new timeout, then a late ack inside ABORT.
        ack_en = 1'b0;
        err_en = 1'b0;
        m_cyc  = 2'b01;
        m_stb  = 2'b01;
        wait_stb("t5b");
        chk("t5b_timeout_pre", 64'(timeout_o), 64'h0);
        stb_cnt = 1;
        for (int i = 0; i < 50; i++) begin
            if (stb_cnt == TO) clr_timeout = 1'b1;
            @(negedge clk);
            clr_timeout = 1'b0;
            if (!s_stb_o) break;
            stb_cnt++;
        end
        chk("t5b_set_wins", 64'(timeout_o), 64'h1);
        chk("t5b_tidx", 64'(timeout_idx_o), 64'h0);
        chk("t5b_m_err", 64'(m_err_o), 64'h1);
        force_ack = 1'b1;
        @(negedge clk);
        chk("t5b_late_ack", 64'(m_ack_o), 64'h0);
        chk("t5b_late_err", 64'(m_err_o), 64'h0);
        force_ack = 1'b0;
        clear_masters();
        @(negedge clk);

        // 6: asynchronous reset mid-BUSY; pointer returns to master 0.
        ack_en = 1'b0;
        m_cyc  = 2'b01;
        m_stb  = 2'b01;
        wait_stb("t6");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_grant", 64'(grant_o), 64'h0);
        chk("t6_s_cyc", 64'(s_cyc_o), 64'h0);
        chk("t6_s_stb", 64'(s_stb_o), 64'h0);
        chk("t6_s_adr", 64'(s_adr_o), 64'h0);
        chk("t6_timeout", 64'(timeout_o), 64'h0);
        @(negedge clk);
        m_cyc = 2'b11;
        m_stb = 2'b11;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ptr_reset", 64'(grant_o), 64'h1);
        clear_masters();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
